// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter
//   Shares one single-port 512x32 BRAM between the Caravel Wishbone slave
//   (firmware) and one user-side engine request port (FIR/DMA). Each access
//   runs IDLE -> ISSUE -> CAPTURE -> WAIT (DELAYS cycles) -> RESP, so a request
//   seen in IDLE at cycle T completes at cycle T+3+DELAYS.
//
//   Optional feature macro: BRAM_ARB_RR_EN
//     defined   : round-robin between WB and engine on simultaneous requests
//     undefined : fixed priority, Wishbone always wins
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_*                     Wishbone slave (window BASE_ADDR[31:24])
//   usr_req_*/usr_we/usr_addr/usr_wdata   engine request (valid/ready)
//   usr_resp_valid/usr_rdata  engine completion pulse and read data
//   bram_en/we/a/di, bram_do  BRAM pins (bram_do registered in the BRAM)
module bram_access_arbiter #(
    parameter int          N         = 9,
    parameter int          DELAYS    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3800_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          usr_req_valid,
    output logic          usr_req_ready,
    input  logic [3:0]    usr_we,
    input  logic [N-1:0]  usr_addr,
    input  logic [31:0]   usr_wdata,
    output logic          usr_resp_valid,
    output logic [31:0]   usr_rdata,
    output logic          bram_en,
    output logic [3:0]    bram_we,
    output logic [31:0]   bram_a,
    output logic [31:0]   bram_di,
    input  logic [31:0]   bram_do
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_CAPTURE, S_WAIT, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          owner_wb_q, owner_wb_d;   // 1: Wishbone owns the access
    logic          wr_q, wr_d;               // access is a write (even with no byte enabled)
    logic [3:0]    we_q, we_d;
    logic [N-1:0]  addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          abort_q, abort_d;         // WB master dropped cyc/stb mid-access
    logic          wb_req, wb_hold, grant_wb, grant_usr;

    // Address bits outside the window tag and word index are don't-care.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[23:N+2], wbs_adr_i[1:0]};

    assign wb_hold = wbs_cyc_i && wbs_stb_i;
    assign wb_req  = wb_hold && (wbs_adr_i[31:24] == BASE_ADDR[31:24]);

`ifdef BRAM_ARB_RR_EN
    logic rr_wb_next_q, rr_wb_next_d;        // 1: WB wins the next tie
    assign grant_wb = wb_req && (!usr_req_valid || rr_wb_next_q);
`else
    assign grant_wb = wb_req;
`endif
    assign grant_usr = usr_req_valid && !grant_wb;

    always_comb begin
        state_d        = state_q;
        owner_wb_d     = owner_wb_q;
        wr_d           = wr_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        cnt_d          = cnt_q;
        abort_d        = abort_q;
`ifdef BRAM_ARB_RR_EN
        rr_wb_next_d   = rr_wb_next_q;
`endif
        wbs_ack_o      = 1'b0;
        wbs_dat_o      = '0;
        usr_req_ready  = 1'b0;
        usr_resp_valid = 1'b0;
        usr_rdata      = '0;
        bram_en        = 1'b0;
        bram_we        = '0;
        bram_a         = '0;
        bram_di        = '0;

        // A WB master that lets go of the bus forfeits its ack.
        if (state_q != S_IDLE && owner_wb_q && !wb_hold)
            abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (grant_wb) begin
                    owner_wb_d = 1'b1;
                    wr_d       = wbs_we_i;
                    we_d       = wbs_we_i ? wbs_sel_i : 4'b0000;
                    addr_d     = wbs_adr_i[N+1:2];
                    wdata_d    = wbs_dat_i;
                    abort_d    = 1'b0;
                    state_d    = S_ISSUE;
`ifdef BRAM_ARB_RR_EN
                    rr_wb_next_d = 1'b0;
`endif
                end else if (grant_usr) begin
                    // Ready is never raised while reset is being applied.
                    usr_req_ready = !wb_rst_i;
                    owner_wb_d    = 1'b0;
                    wr_d          = (usr_we != 4'b0000);
                    we_d          = usr_we;
                    addr_d        = usr_addr;
                    wdata_d       = usr_wdata;
                    abort_d       = 1'b0;
                    state_d       = S_ISSUE;
`ifdef BRAM_ARB_RR_EN
                    rr_wb_next_d  = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                bram_en = 1'b1;
                bram_we = we_q;
                bram_a  = 32'(addr_q);
                bram_di = wdata_q;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Writes complete with zero data regardless of what Do0 shows.
                rdata_d = wr_q ? 32'h0 : bram_do;
                if (DELAYS == 0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 8'(DELAYS - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_RESP: begin
                if (owner_wb_q) begin
                    if (!abort_q && wb_hold) begin
                        wbs_ack_o = 1'b1;
                        wbs_dat_o = rdata_q;
                    end
                end else begin
                    usr_resp_valid = 1'b1;
                    usr_rdata      = rdata_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            owner_wb_q   <= 1'b0;
            wr_q         <= 1'b0;
            we_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
`ifdef BRAM_ARB_RR_EN
            rr_wb_next_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_wb_q   <= owner_wb_d;
            wr_q         <= wr_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
`ifdef BRAM_ARB_RR_EN
            rr_wb_next_q <= rr_wb_next_d;
`endif
        end
    end

endmodule

// File: tb/tb_bram_access_arbiter.sv
module tb_bram_access_arbiter;
    localparam int N      = 9;
    localparam int DELAYS = 10;
    localparam int LAT    = 3 + DELAYS;

    logic        clk, rst;
    logic        cyc, stb, wwe;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        uvalid, uready;
    logic [3:0]  uwe;
    logic [N-1:0] uaddr;
    logic [31:0] uwdata;
    logic        uresp;
    logic [31:0] urdata;
    logic        ben;
    logic [3:0]  bwe;
    logic [31:0] ba, bdi, bdo;

    bram_access_arbiter #(.N(N), .DELAYS(DELAYS), .BASE_ADDR(32'h3800_0000)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(wwe), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .usr_req_valid(uvalid), .usr_req_ready(uready), .usr_we(uwe),
        .usr_addr(uaddr), .usr_wdata(uwdata), .usr_resp_valid(uresp), .usr_rdata(urdata),
        .bram_en(ben), .bram_we(bwe), .bram_a(ba), .bram_di(bdi), .bram_do(bdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // BRAM: registered read, output forced to 0 on edges where EN is low.
    logic [31:0] bmem [512];
    initial begin
        for (int i = 0; i < 512; i++) bmem[i] = '0;
        bdo = '0;
    end
    always @(posedge clk) begin
        if (ben) begin
            bdo <= bmem[ba[8:0]];
            for (int b = 0; b < 4; b++)
                if (bwe[b]) bmem[ba[8:0]][b*8 +: 8] <= bdi[b*8 +: 8];
        end else begin
            bdo <= '0;
        end
    end

    // Reference model: memory image, tie pointer, and when the block is free.
    typedef struct {
        bit          is_wb;
        bit          chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] mem_m [512];
    bit          rr_wb_next;
    int          busy_until;
    int          n_cmp, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc_cnt);
    endtask

    // A request seen at req_cyc is granted as soon as the block is free and
    // completes LAT cycles after its grant.
    task automatic model_txn(input bit is_wb, input bit wr, input logic [3:0] we,
                             input logic [8:0] idx, input logic [31:0] d, input int req_cyc);
        exp_t e;
        int   start;
        start   = (req_cyc > busy_until) ? req_cyc : busy_until + 1;
        e.is_wb = is_wb;
        e.cyc   = start + LAT;
        e.data  = wr ? 32'h0 : mem_m[idx];
        e.chk   = is_wb || !wr;
        for (int b = 0; b < 4; b++)
            if (we[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
        busy_until = e.cyc;
        rr_wb_next = !is_wb;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack || uresp) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_completion");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_side", {31'b0, ack}, {31'b0, e.is_wb});
                    chk("resp_exclusive", {31'b0, ack & uresp}, 32'h0);
                    chk("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
                    if (e.chk) chk("resp_data", ack ? rdat : urdata, e.data);
                end
            end else begin
                chk("wbs_dat_o_idle", rdat, 32'h0);
                chk("usr_rdata_idle", urdata, 32'h0);
            end
            if (!ben) chk("bram_pins_idle", {28'b0, bwe} | ba | bdi, 32'h0);
        end
    end

    task automatic wb_go(input logic we, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input bit chk_issue);
        bit got;
        cyc = 1'b1; stb = 1'b1; wwe = we; sel = s; adr = a; wdat = d;
        if (chk_issue) begin
            @(negedge clk);
            @(negedge clk);
            chk("issue_en", {31'b0, ben}, 32'h1);
            chk("issue_we", {28'b0, bwe}, {28'b0, we ? s : 4'b0000});
            chk("issue_a", ba, {23'b0, a[10:2]});
            chk("issue_di", bdi, d);
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        if (!got) fail_now("wb_ack_timeout");
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; wwe = 1'b0;
    endtask

    task automatic usr_go(input logic [3:0] we, input logic [8:0] a, input logic [31:0] d,
                          input bit chk_issue);
        bit got;
        uvalid = 1'b1; uwe = we; uaddr = a; uwdata = d;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (uready) got = 1'b1;
        end
        if (!got) fail_now("usr_ready_timeout");
        @(posedge clk); #1;
        uvalid = 1'b0;
        if (chk_issue) begin
            @(negedge clk);
            chk("issue_en", {31'b0, ben}, 32'h1);
            chk("issue_we", {28'b0, bwe}, {28'b0, we});
            chk("issue_a", ba, {23'b0, a});
            chk("issue_di", bdi, d);
        end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (uresp) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) fail_now("usr_resp_timeout");
    endtask

    task automatic do_wb(input logic we, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        model_txn(1'b1, we, we ? s : 4'b0000, a[10:2], d, cyc_cnt);
        wb_go(we, s, a, d, 1'b1);
    endtask

    task automatic do_usr(input logic [3:0] we, input logic [8:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        model_txn(1'b0, we != 4'b0000, we, a, d, cyc_cnt);
        usr_go(we, a, d, 1'b1);
    endtask

    // WB and engine raise requests in the same cycle.
    task automatic do_both(input logic [31:0] wa, input logic [31:0] wd,
                           input logic [8:0] ua, input logic [31:0] ud);
        bit wb_first;
        int t;
        @(posedge clk); #1;
        t = cyc_cnt;
`ifdef BRAM_ARB_RR_EN
        wb_first = rr_wb_next;
`else
        wb_first = 1'b1;
`endif
        if (wb_first) begin
            model_txn(1'b1, 1'b1, 4'hF, wa[10:2], wd, t);
            model_txn(1'b0, 1'b0, 4'h0, ua, ud, t);
        end else begin
            model_txn(1'b0, 1'b0, 4'h0, ua, ud, t);
            model_txn(1'b1, 1'b1, 4'hF, wa[10:2], wd, t);
        end
        fork
            wb_go(1'b1, 4'hF, wa, wd, 1'b0);
            usr_go(4'h0, ua, ud, 1'b0);
        join
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        for (int i = 0; i < 512; i++) mem_m[i] = '0;
        rr_wb_next = 1'b1;
        cyc = 0; stb = 0; wwe = 0; sel = 0; adr = 0; wdat = 0;
        uvalid = 0; uwe = 0; uaddr = 0; uwdata = 0;

        // Reset with both requesters active: nothing may respond.
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; adr = 32'h3800_0000; uvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_ready", {31'b0, uready}, 32'h0);
        chk("rst_resp", {31'b0, uresp}, 32'h0);
        chk("rst_bram", {27'b0, ben, bwe} | ba | bdi, 32'h0);
        chk("rst_data", rdat | urdata, 32'h0);
        cyc = 1'b0; stb = 1'b0; uvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        busy_until = cyc_cnt;

        // Directed: write/read through both ports, partial engine write.
        do_wb(1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF);
        do_wb(1'b0, 4'hF, 32'h3800_0010, 32'h0);
        do_usr(4'b0000, 9'd4, 32'h0);
        do_usr(4'b0011, 9'd4, 32'h0000_1234);
        do_usr(4'b0000, 9'd4, 32'h0);
        do_wb(1'b1, 4'b0000, 32'h3800_0010, 32'h5555_5555);
        do_wb(1'b0, 4'hF, 32'h38FF_F810, 32'h0);

        // Simultaneous requests, twice.
        do_both(32'h3800_0020, 32'hA5A5_0001, 9'd4, 32'h0);
        do_both(32'h3800_0024, 32'hA5A5_0002, 9'd8, 32'h0);

        // Randomised traffic over a small hot address set.
        for (int k = 0; k < 60; k++) begin
            logic [8:0]  idx;
            logic [31:0] d;
            idx = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
            d   = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_wb(1'($urandom), 4'($urandom), {8'h38, 13'($urandom), idx, 2'b00}, d);
            else
                do_usr(($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, idx, d);
        end

        // Reset pulsed in the WAIT phase of a WB read: aborted, no ack.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; wwe = 1'b0; sel = 4'hF; adr = 32'h3800_0010;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {29'b0, ack, uresp, ben} | rdat | urdata | ba, 32'h0);
        repeat (20) @(negedge clk);
        rr_wb_next = 1'b1;
        busy_until = cyc_cnt;
        do_wb(1'b0, 4'hF, 32'h3800_0010, 32'h0);

        // Out-of-window WB access is ignored; engine is still served.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; wwe = 1'b1; sel = 4'hF; adr = 32'h3000_0010; wdat = 32'hBAD0_BAD0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("oow_bram_en", {31'b0, ben}, 32'h0);
            chk("oow_ack", {31'b0, ack}, 32'h0);
        end
        @(posedge clk); #1;
        model_txn(1'b0, 1'b0, 4'h0, 9'd4, 32'h0, cyc_cnt);
        usr_go(4'h0, 9'd4, 32'h0, 1'b1);
        repeat (15) @(negedge clk);
        cyc = 1'b0; stb = 1'b0; wwe = 1'b0;
        do_usr(4'h0, 9'd4, 32'h0);

        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
